// File: rtl/tt_scan_pkg.sv
// tt_scan_pkg: shared scanner state encoding, default sizing constants and
// the truth-vector width derivation used by tt_scanner and tt_first_one.
package tt_scan_pkg;

  localparam int N_IN_DEF   = 3;
  localparam int SETTLE_DEF = 1;

  // One truth-vector bit per input combination.
  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

endpackage

// File: rtl/tt_first_one.sv
// tt_first_one: index of the lowest set bit of vec; returns 0 when vec is 0.
module tt_first_one
  import tt_scan_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int W    = tt_width(N_IN)
) (
  input  logic [W-1:0]    vec,
  output logic [N_IN-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = N_IN'(i);
    end
  end

endmodule

// File: rtl/tt_scanner.sv
// tt_scanner: walks abc through every input combination of a combinational
// function, waits SETTLE cycles per combination, then samples dut_s into
// tt_vec[abc]. With macro TT_COMPARE_EN defined, the captured vector is also
// compared against ref_vec latched at start (mismatch / err_idx); otherwise
// those outputs are tied low and ref_vec is not used.
module tt_scanner
  import tt_scan_pkg::*;
#(
  parameter int  N_IN   = N_IN_DEF,
  parameter int  SETTLE = SETTLE_DEF,
  localparam int W      = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    ref_vec,
  input  logic            dut_s,
  output logic [N_IN-1:0] abc,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    tt_vec,
  output logic            mismatch,
  output logic [N_IN-1:0] err_idx
);

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] ABC_LAST    = '1;

  state_t       state;
  logic [3:0]   settle_cnt;
  logic [W-1:0] cap_vec;

  // Truth vector as it looks once the current sample has been written.
  always_comb begin
    cap_vec      = tt_vec;
    cap_vec[abc] = dut_s;
  end

  // Scan sequencer: IDLE -> (SETTLE x SETTLE cycles, SAMPLE) per index -> DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      abc        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt_vec     <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tt_vec     <= '0;
            abc        <= '0;
            busy       <= 1'b1;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          tt_vec <= cap_vec;
          if (abc == ABC_LAST) begin
            // abc is left at W-1 until the next accepted start.
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            abc   <= abc + 1'b1;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TT_COMPARE_EN
  logic [W-1:0]    ref_lat;
  logic [N_IN-1:0] first_idx;

  tt_first_one #(
    .N_IN (N_IN),
    .W    (W)
  ) u_first_one (
    .vec (cap_vec ^ ref_lat),
    .idx (first_idx)
  );

  // Latch the reference at start; judge the complete vector on the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_lat  <= '0;
      mismatch <= 1'b0;
      err_idx  <= '0;
    end else if (state == S_IDLE && start) begin
      ref_lat  <= ref_vec;
      mismatch <= 1'b0;
      err_idx  <= '0;
    end else if (state == S_SAMPLE && abc == ABC_LAST) begin
      mismatch <= (cap_vec != ref_lat);
      err_idx  <= first_idx;
    end
  end
`else
  logic unused_ref;
  assign unused_ref = ^ref_vec;
  assign mismatch   = 1'b0;
  assign err_idx    = '0;
`endif

endmodule

// File: tb/tb_tt_scanner.sv
// tb_tt_scanner: directed and randomized scans of tt_scanner against a
// behavioural model (cycle k after acceptance maps to index k/(SETTLE+1)).
module tb_tt_scanner;

`ifdef TT_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [7:0] func0, func1, ref0, ref1;
  logic       dut_s0, dut_s1;
  logic [2:0] abc0, abc1, err_idx0, err_idx1;
  logic       busy0, busy1, done0, done1, mismatch0, mismatch1;
  logic [7:0] tt_vec0, tt_vec1;

  // Function under test: an arbitrary truth table indexed by abc.
  assign dut_s0 = func0[abc0];
  assign dut_s1 = func1[abc1];

  tt_scanner #(.N_IN(3), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ref_vec(ref0), .dut_s(dut_s0),
    .abc(abc0), .busy(busy0), .done(done0), .tt_vec(tt_vec0),
    .mismatch(mismatch0), .err_idx(err_idx0)
  );

  tt_scanner #(.N_IN(3), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ref_vec(ref1), .dut_s(dut_s1),
    .abc(abc1), .busy(busy1), .done(done1), .tt_vec(tt_vec1),
    .mismatch(mismatch1), .err_idx(err_idx1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_mm(input logic [7:0] fn, input logic [7:0] rv);
    return CMP && (fn != rv);
  endfunction

  function automatic int exp_err(input logic [7:0] fn, input logic [7:0] rv);
    int x;
    x = int'(fn ^ rv);
    if (!CMP || x == 0) return 0;
    return $clog2(x & -x);
  endfunction

  // One scan on u0 (SETTLE=1): done expected 16 cycles after acceptance.
  task automatic scan0(input logic [7:0] fn, input logic [7:0] rv,
                       input bit repulse, input string tag);
    int first_done;
    int n_done;
    func0  = fn;
    ref0   = rv;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    ref0   = ~rv;   // changes during the scan must not matter
    chk({tag, ":busy_start"}, 32'(busy0), 32'd1);
    chk({tag, ":abc_start"}, 32'(abc0), 32'd0);
    first_done = -1;
    n_done     = 0;
    for (int k = 1; k <= 20; k++) begin
      start0 = repulse && (k == 5 || k == 17);
      @(negedge clk);
      if (done0) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      chk({tag, ":abc_step"}, 32'(abc0), 32'((k < 16) ? k / 2 : 7));
      chk({tag, ":busy_step"}, 32'(busy0), 32'(k < 16));
      if (k == 16) begin
        chk({tag, ":tt_vec"}, 32'(tt_vec0), 32'(fn));
        chk({tag, ":mismatch"}, 32'(mismatch0), 32'(exp_mm(fn, rv)));
        chk({tag, ":err_idx"}, 32'(err_idx0), 32'(exp_err(fn, rv)));
      end
    end
    start0 = 1'b0;
    chk({tag, ":done_latency"}, 32'(first_done), 32'd16);
    chk({tag, ":done_count"}, 32'(n_done), 32'd1);
    chk({tag, ":tt_vec_held"}, 32'(tt_vec0), 32'(fn));
    chk({tag, ":mismatch_held"}, 32'(mismatch0), 32'(exp_mm(fn, rv)));
    $display("scan %s fn=%02h ref=%02h tt_vec=%02h mismatch=%0d err_idx=%0d",
             tag, fn, rv, tt_vec0, mismatch0, err_idx0);
  endtask

  initial begin
    int d1, d2, n_done;
    logic [7:0] fn, rv;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    func0  = 8'h4E;
    func1  = 8'h4E;
    ref0   = 8'h00;
    ref1   = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst:abc", 32'(abc0), 32'd0);
    chk("rst:busy", 32'(busy0), 32'd0);
    chk("rst:done", 32'(done0), 32'd0);
    chk("rst:tt_vec", 32'(tt_vec0), 32'd0);
    chk("rst:mismatch", 32'(mismatch0), 32'd0);
    chk("rst:err_idx", 32'(err_idx0), 32'd0);
    chk("rst:busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle:busy", 32'(busy0), 32'd0);

    // Directed scans with the reference function 0x4E.
    scan0(8'h4E, 8'h4E, 1'b0, "match");
    scan0(8'h4E, 8'h4F, 1'b0, "ref4F");
    scan0(8'h4E, 8'hCE, 1'b0, "refCE");
    scan0(8'h4E, 8'h4E, 1'b1, "repulse");

    // Reset mid-scan at abc=3, then restart.
    func0  = 8'h4E;
    ref0   = 8'h00;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort:abc_pre", 32'(abc0), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("abort:abc", 32'(abc0), 32'd0);
    chk("abort:busy", 32'(busy0), 32'd0);
    chk("abort:done", 32'(done0), 32'd0);
    chk("abort:tt_vec", 32'(tt_vec0), 32'd0);
    chk("abort:mismatch", 32'(mismatch0), 32'd0);
    chk("abort:err_idx", 32'(err_idx0), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done0) n_done++;
    end
    chk("abort:no_done", 32'(n_done), 32'd0);
    chk("abort:idle", 32'(busy0), 32'd0);
    scan0(8'h4E, 8'h4E, 1'b0, "restart");

    // Start held high: back-to-back scans, dones at cycles 16 and 34.
    func0  = 8'h4E;
    ref0   = 8'h4E;
    start0 = 1'b1;
    @(negedge clk);
    d1 = -1;
    d2 = -1;
    n_done = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (done0) begin
        n_done++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 17) chk("held:idle_gap", 32'(busy0), 32'd0);
      if (k == 18) begin
        chk("held:busy2", 32'(busy0), 32'd1);
        chk("held:abc2", 32'(abc0), 32'd0);
        chk("held:tt_clear", 32'(tt_vec0), 32'd0);
      end
    end
    start0 = 1'b0;
    chk("held:done1", 32'(d1), 32'd16);
    chk("held:done2", 32'(d2), 32'd34);
    chk("held:count", 32'(n_done), 32'd2);
    chk("held:tt_vec", 32'(tt_vec0), 32'h4E);
    $display("scan held-start done at %0d and %0d", d1, d2);
    repeat (2) @(negedge clk);

    // SETTLE=3 instance: abc steps every 4 cycles, done at 32.
    ref1   = 8'h4F;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    ref1   = 8'h00;
    d1 = -1;
    n_done = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (done1) begin
        n_done++;
        if (d1 < 0) d1 = k;
      end
      chk("s3:abc_step", 32'(abc1), 32'((k < 32) ? k / 4 : 7));
    end
    chk("s3:done_latency", 32'(d1), 32'd32);
    chk("s3:done_count", 32'(n_done), 32'd1);
    chk("s3:tt_vec", 32'(tt_vec1), 32'h4E);
    chk("s3:mismatch", 32'(mismatch1), 32'(exp_mm(8'h4E, 8'h4F)));
    chk("s3:err_idx", 32'(err_idx1), 32'(exp_err(8'h4E, 8'h4F)));
    $display("scan settle3 tt_vec=%02h done at %0d", tt_vec1, d1);

    // Randomized functions and references.
    for (int r = 0; r < 8; r++) begin
      fn = 8'($urandom);
      rv = ($urandom_range(0, 2) == 0) ? fn : 8'($urandom);
      scan0(fn, rv, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_scanner.md
TT_SCANNER -- requirements
Module: tt_scanner

Interface
REQ-001 SHALL have parameter N_IN, default 3, number of inputs of the function under test (1..6).
REQ-002 SHALL have parameter SETTLE, default 1, number of settle cycles per input combination (1..15).
REQ-003 SHALL define derived width W = 2**N_IN, the truth-vector width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  scan request, sampled only in IDLE.
REQ-007 SHALL have port ref_vec  in  W  expected truth vector; bit i = expected output for input i.
REQ-008 SHALL have port dut_s  in  1  output of the combinational function under test.
REQ-009 SHALL have port abc  out  N_IN  stimulus to the function under test; MSB = a.
REQ-010 SHALL have port busy  out  1  high while a scan is in progress.
REQ-011 SHALL have port done  out  1  one-cycle pulse at scan completion.
REQ-012 SHALL have port tt_vec  out  W  captured truth vector.
REQ-013 SHALL have port mismatch  out  1  captured vector differs from latched ref.
REQ-014 SHALL have port err_idx  out  N_IN  lowest mismatching index.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 SHALL, in IDLE with start=1: clear tt_vec, latch ref_vec, set abc=0, busy=1, and go to SETTLE.
REQ-017 SHALL hold SETTLE for exactly SETTLE cycles, using an internal counter, then go to SAMPLE.
REQ-018 SHALL, on the SAMPLE edge, write tt_vec[abc] = dut_s; if abc = W-1 go to DONE, else increment abc and go to SETTLE.
REQ-019 SHALL spend SETTLE+1 cycles per index, giving a total of W*(SETTLE+1) cycles from start acceptance to entry into DONE.
REQ-020 SHALL, in DONE, assert done=1 and busy=0 for one cycle, then return to IDLE.
REQ-021 SHALL ignore start outside IDLE; start held high SHALL begin a new scan on the cycle after DONE.
REQ-022 SHALL never wrap abc past W-1 within a scan; abc SHALL hold W-1 after the scan ends until the next start.
REQ-023 SHALL hold tt_vec, mismatch and err_idx stable from DONE until the next accepted start.
REQ-024 SHALL ignore changes to ref_vec during a scan.

Reset
REQ-025 SHALL, on rst_n=0 at any time (including mid-scan), immediately force state=IDLE, abc=0, busy=0, done=0, tt_vec=0, mismatch=0, err_idx=0, and clear the settle counter.
REQ-026 SHALL discard any partial capture on reset; no done SHALL be issued for an aborted scan.

Configuration
REQ-027 SHALL, when macro TT_COMPARE_EN is defined, compute mismatch = (tt_vec != latched ref) and err_idx = lowest set bit of the XOR, both updated on entry to DONE.
REQ-028 SHALL, when TT_COMPARE_EN is undefined, tie mismatch=0 and err_idx=0, leave ref_vec unused, and not implement the latched-ref register.

Structure
REQ-029 SHALL place the state enum, the default N_IN and SETTLE constants, and the W derivation in shared package tt_scan_pkg.
REQ-030 SHALL implement lowest-set-bit detection in sub-module tt_first_one (W in, N_IN index out), instantiated only under TT_COMPARE_EN.

Verification
REQ-031 SHALL cover: DUT s = ~a~bc | ~ab~c | ~abc | ab~c, N_IN=3, SETTLE=1, ref=8'h4E, pulse start -> done 16 cycles after acceptance, tt_vec=8'h4E, mismatch=0.
REQ-032 SHALL cover: same DUT, ref=8'h4F -> tt_vec=8'h4E, mismatch=1, err_idx=0.
REQ-033 SHALL cover: same DUT, ref=8'hCE -> mismatch=1, err_idx=7.
REQ-034 SHALL cover: rst_n low while abc=3 mid-scan -> all outputs 0 and no done; restart -> normal completion with tt_vec=8'h4E.
REQ-035 SHALL cover: start re-pulsed while busy -> ignored, single done; start held high -> back-to-back scans with one idle cycle between them.
REQ-036 SHALL cover: SETTLE=3 -> done 32 cycles after acceptance; abc stepped 0..7 every 4 cycles.
